// File: rtl/qpsk_symbol_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : qpsk_symbol_scheduler_if
// Brief    : Byte-stream handshake between the packet source and the scheduler.
// Revision : 1.0
// ============================================================================
interface qpsk_symbol_scheduler_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (output s_data, output s_valid, output s_last, input  s_ready);
    modport slave  (input  s_data, input  s_valid, input  s_last, output s_ready);
endinterface
`default_nettype wire

// File: rtl/qpsk_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : qpsk_symbol_scheduler
// Brief    : Buffers bytes in a small FIFO and emits one dibit (MSB first) per
//            SYM_LEN-clock symbol to the QPSK modulator. Optional preamble via
//            the QPSK_PREAMBLE_EN macro.
// Revision : 1.0
// ============================================================================
module qpsk_symbol_scheduler #(
    parameter int SYM_LEN      = 120,
    parameter int FIFO_DEPTH   = 4,
    parameter int PREAMBLE_LEN = 8
) (
    input  wire                      clk,
    input  wire                      rst,
    input  wire                      enable,
    qpsk_symbol_scheduler_if.slave   src,
    output logic [1:0]               qpsk_base_data,
    output logic                     sym_strobe,
    output logic                     tx_active,
    output logic                     underrun
);
    localparam int c_cnt_w  = $clog2(SYM_LEN);
    localparam int c_addr_w = $clog2(FIFO_DEPTH);
    localparam int c_pre_w  = $clog2(PREAMBLE_LEN + 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_max  = c_cnt_w'(SYM_LEN - 1);
    localparam logic [c_addr_w:0]   c_depth    = (c_addr_w + 1)'(FIFO_DEPTH);

    if (SYM_LEN < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PREAMBLE_LEN < 1 || c_pre_w < 1) begin : g_param_check
        $error("qpsk_symbol_scheduler: illegal parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
`ifdef QPSK_PREAMBLE_EN
        ST_PREAMBLE = 2'd2,
`endif
        ST_DATA     = 2'd1
    } state_t;

    // FIFO storage: {last, data}
    logic [8:0]          r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic                w_full, w_empty, w_push, w_pop, w_flush;
    logic [8:0]          w_head;

    state_t              r_state, w_nxt_state;
    logic [c_cnt_w-1:0]  r_cnt, w_nxt_cnt;
    logic [1:0]          r_data, w_nxt_data;
    logic                r_strobe, w_nxt_strobe, r_underrun, w_nxt_underrun;
    logic [7:0]          r_byte, w_nxt_byte;
    logic [1:0]          r_idx, w_nxt_idx;
    logic                r_busy, w_nxt_busy, r_last, w_nxt_last, r_done, w_nxt_done;
    logic                w_bnd;
    logic [2:0]          w_sel;
`ifdef QPSK_PREAMBLE_EN
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PREAMBLE_LEN - 1);
    logic [c_pre_w-1:0]  r_pre, w_nxt_pre;
`endif

    assign w_full      = (r_count == c_depth);
    assign w_empty     = (r_count == '0);
    assign w_push      = src.s_valid && !w_full;
    assign w_head      = r_mem[r_rd_ptr];
    assign src.s_ready = !w_full;

    assign w_bnd = (r_cnt == c_cnt_max);
    assign w_sel = {~r_idx, 1'b0};

    assign qpsk_base_data = r_data;
    assign sym_strobe     = r_strobe;
    assign underrun       = r_underrun;
    assign tx_active      = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (w_push && !w_flush) begin
            r_mem[r_wr_ptr] <= {src.s_last, src.s_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{c_addr_w{1'b0}}, w_push} - {{c_addr_w{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_data     <= 2'b00;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
            r_byte     <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
`ifdef QPSK_PREAMBLE_EN
            r_pre      <= '0;
`endif
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_data     <= w_nxt_data;
            r_strobe   <= w_nxt_strobe;
            r_underrun <= w_nxt_underrun;
            r_byte     <= w_nxt_byte;
            r_idx      <= w_nxt_idx;
            r_busy     <= w_nxt_busy;
            r_last     <= w_nxt_last;
            r_done     <= w_nxt_done;
`ifdef QPSK_PREAMBLE_EN
            r_pre      <= w_nxt_pre;
`endif
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_cnt      = w_bnd ? '0 : r_cnt + 1'b1;
        w_nxt_data     = r_data;
        w_nxt_strobe   = 1'b0;
        w_nxt_underrun = 1'b0;
        w_nxt_byte     = r_byte;
        w_nxt_idx      = r_idx;
        w_nxt_busy     = r_busy;
        w_nxt_last     = r_last;
        w_nxt_done     = r_done;
        w_pop          = 1'b0;
        w_flush        = 1'b0;
`ifdef QPSK_PREAMBLE_EN
        w_nxt_pre      = r_pre;
`endif
        if (r_state != ST_IDLE && w_bnd && !enable) begin
            // Abort only at a symbol boundary so the current symbol is never truncated
            w_nxt_state = ST_IDLE;
            w_nxt_cnt   = '0;
            w_nxt_data  = 2'b00;
            w_nxt_busy  = 1'b0;
            w_nxt_done  = 1'b0;
            w_flush     = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nxt_cnt  = '0;
                    w_nxt_data = 2'b00;
                    if (enable && !w_empty) begin
                        // Preload the counter so the first symbol loads on the next clock
                        w_nxt_cnt  = c_cnt_max;
                        w_nxt_busy = 1'b0;
                        w_nxt_done = 1'b0;
`ifdef QPSK_PREAMBLE_EN
                        w_nxt_pre   = '0;
                        w_nxt_state = ST_PREAMBLE;
`else
                        w_nxt_state = ST_DATA;
`endif
                    end
                end
`ifdef QPSK_PREAMBLE_EN
                ST_PREAMBLE: begin
                    if (w_bnd) begin
                        w_nxt_strobe = 1'b1;
                        w_nxt_data   = r_pre[0] ? 2'b11 : 2'b00;
                        w_nxt_pre    = r_pre + 1'b1;
                        if (r_pre == c_pre_last) w_nxt_state = ST_DATA;
                    end
                end
`endif
                ST_DATA: begin
                    if (w_bnd) begin
                        if (r_busy) begin
                            w_nxt_strobe = 1'b1;
                            w_nxt_data   = r_byte[w_sel +: 2];
                            w_nxt_idx    = r_idx + 1'b1;
                            if (r_idx == 2'd3) begin
                                w_nxt_busy = 1'b0;
                                w_nxt_done = r_last;
                            end
                        end else if (r_done) begin
                            w_nxt_state = ST_IDLE;
                            w_nxt_cnt   = '0;
                            w_nxt_data  = 2'b00;
                            w_nxt_done  = 1'b0;
                        end else if (!w_empty) begin
                            w_pop        = 1'b1;
                            w_nxt_strobe = 1'b1;
                            w_nxt_data   = w_head[7:6];
                            w_nxt_byte   = w_head[7:0];
                            w_nxt_last   = w_head[8];
                            w_nxt_idx    = 2'd1;
                            w_nxt_busy   = 1'b1;
                        end else begin
                            w_nxt_strobe   = 1'b1;
                            w_nxt_underrun = 1'b1;
                            w_nxt_data     = 2'b00;
                        end
                    end
                end
                default: w_nxt_state = ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_qpsk_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_qpsk_symbol_scheduler
// Brief    : Scoreboard bench: stimulus queues expected {underrun,dibit} per
//            symbol, a negedge monitor pops and compares on every sym_strobe.
// Revision : 1.0
// ============================================================================
module tb_qpsk_symbol_scheduler;
    localparam int SYM = 4;
`ifdef QPSK_PREAMBLE_EN
    localparam int PRE = 8;
`else
    localparam int PRE = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] qd;
    logic       ss, txa, und;

    qpsk_symbol_scheduler_if bus();

    qpsk_symbol_scheduler #(
        .SYM_LEN      (SYM),
        .FIFO_DEPTH   (4),
        .PREAMBLE_LEN (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .src            (bus),
        .qpsk_base_data (qd),
        .sym_strobe     (ss),
        .tx_active      (txa),
        .underrun       (und)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [2:0] exp_q[$];
    int         strobe_cnt = 0;
    logic [1:0] held = 2'b00;
    int         gap = 0;
    bit         have_prev = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_preamble();
        for (int i = 0; i < PRE; i++) exp_q.push_back({1'b0, (i % 2) ? 2'b11 : 2'b00});
    endtask

    task automatic exp_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, b[7-2*k -: 2]});
    endtask

    // Monitor: compares every emitted symbol against the scoreboard
    always @(negedge clk) begin
        logic [2:0] e;
        if (rst) begin
            have_prev = 1'b0;
            held      = 2'b00;
        end else if (ss) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                check("sym_queue_nonempty", int'(exp_q.size() != 0), 1);
            end else begin
                e = exp_q.pop_front();
                check("dibit", int'(qd), int'(e[1:0]));
                check("underrun", int'(und), int'(e[2]));
            end
            if (have_prev) check("sym_period", gap, SYM);
            held      = qd;
            have_prev = 1'b1;
            gap       = 1;
        end else begin
            check("underrun_no_strobe", int'(und), 0);
            if (txa) begin
                gap++;
                check("dibit_hold", int'(qd), int'(held));
            end else begin
                have_prev = 1'b0;
                held      = 2'b00;
                check("idle_output", int'(qd), 0);
            end
        end
    end

    task automatic write_byte(input logic [7:0] d, input logic l);
        int t = 0;
        bus.s_data  = d;
        bus.s_last  = l;
        bus.s_valid = 1'b1;
        while (!bus.s_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("write_accept_timeout", int'(t < 200), 1);
        @(posedge clk); #1;
    endtask

    task automatic bus_idle();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((txa || exp_q.size() != 0) && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        check("idle_timeout", int'(t < budget), 1);
    endtask

    task automatic wait_strobe(input int budget);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ss && t < budget);
        check("strobe_timeout", int'(t < budget), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int s0;
        rst = 1'b1; enable = 1'b0;
        bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", int'(qd), 0);
        check("rst_strobe", int'(ss), 0);
        check("rst_active", int'(txa), 0);
        check("rst_underrun", int'(und), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", int'(bus.s_ready), 1);

        // Single byte 0xB4: latency and burst length
        enable = 1'b1;
        push_preamble(); exp_byte(8'hB4);
        write_byte(8'hB4, 1'b1);
        bus_idle();
        @(negedge clk); check("lat_idle_T", int'(txa), 0);
        @(negedge clk); check("lat_active_T1", int'(txa), 1); check("lat_nostrobe_T1", int'(ss), 0);
        @(negedge clk); check("lat_strobe_T2", int'(ss), 1);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (txa && c < 400);
        check("burst_length", c, (4 + PRE) * SYM);
        check("burst_end_data", int'(qd), 0);

        // Back-to-back bytes, no gap
        push_preamble(); exp_byte(8'h1B); exp_byte(8'hE4);
        @(posedge clk); #1;
        write_byte(8'h1B, 1'b0);
        write_byte(8'hE4, 1'b1);
        bus_idle();
        wait_idle(400);

        // Underrun: two empty symbols then a late last byte
        push_preamble(); exp_byte(8'hFF);
        exp_q.push_back(3'b100); exp_q.push_back(3'b100);
        exp_byte(8'h00);
        write_byte(8'hFF, 1'b0);
        bus_idle();
        repeat (23 + PRE * SYM) @(posedge clk);
        #1;
        write_byte(8'h00, 1'b1);
        bus_idle();
        wait_idle(400);

        // FIFO fill while disabled, then drain in order
        enable = 1'b0;
        push_preamble();
        exp_byte(8'h11); exp_byte(8'h22); exp_byte(8'h33);
        exp_byte(8'h44); exp_byte(8'h55); exp_byte(8'h66);
        write_byte(8'h11, 1'b0);
        write_byte(8'h22, 1'b0);
        write_byte(8'h33, 1'b0);
        write_byte(8'h44, 1'b0);
        check("full_ready_low", int'(bus.s_ready), 0);
        check("full_idle", int'(txa), 0);
        enable = 1'b1;
        write_byte(8'h55, 1'b0);
        write_byte(8'h66, 1'b1);
        bus_idle();
        wait_idle(600);

        // Abort mid-symbol: symbol completes, FIFO flushed
        exp_q.push_back(PRE > 0 ? 3'b000 : 3'b010);
        write_byte(8'h9C, 1'b0);
        write_byte(8'h3C, 1'b1);
        bus_idle();
        wait_strobe(100);
        @(posedge clk); #1;
        enable = 1'b0;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (txa && c < 100);
        check("abort_symbol_len", c, SYM);
        check("abort_ready", int'(bus.s_ready), 1);
        @(posedge clk); #1;
        enable = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_flushed", int'(txa), 0);

        // Reset mid-burst
        @(posedge clk); #1;
        exp_q.push_back(PRE > 0 ? 3'b000 : 3'b001);
        write_byte(8'h5A, 1'b1);
        bus_idle();
        wait_strobe(100);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_data", int'(qd), 0);
        check("midrst_strobe", int'(ss), 0);
        check("midrst_active", int'(txa), 0);
        check("midrst_underrun", int'(und), 0);
        check("midrst_ready", int'(bus.s_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_stays_idle", int'(txa), 0);

        // 0xC0: preamble (if built in) then 11,00,00,00
        @(posedge clk); #1;
        push_preamble(); exp_byte(8'hC0);
        s0 = strobe_cnt;
        write_byte(8'hC0, 1'b1);
        bus_idle();
        wait_idle(400);
        check("strobe_total", strobe_cnt - s0, 4 + PRE);

        repeat (5) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
